// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Build option SUB_CLAMP_EN (see serial_subtractor.sv) does not affect this package.
package sub_pkg;

   localparam int SUB_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master = upstream/downstream environment, slave = the subtractor itself.
interface serial_subtractor_if
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEFAULT
);

   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] r1_i;
   logic [WIDTH-1:0] r2_i;
   logic             bi_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] result_o;
   logic             borrow_o;

   modport master (
      output valid_i,
      output r1_i,
      output r2_i,
      output bi_i,
      output ready_i,
      input  ready_o,
      input  valid_o,
      input  result_o,
      input  borrow_o
   );

   modport slave (
      input  valid_i,
      input  r1_i,
      input  r2_i,
      input  bi_i,
      input  ready_i,
      output ready_o,
      output valid_o,
      output result_o,
      output borrow_o
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bi, LSB first, one full_subtractor reused for WIDTH cycles.
// Define SUB_CLAMP_EN to saturate the result to zero whenever the final borrow is set.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
   input logic                clk_i,
   input logic                rst_ni,
   serial_subtractor_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0]    ST_IDLE  = IDLE;
   localparam logic [1:0]    ST_SHIFT = SHIFT;
   localparam logic [1:0]    ST_DONE  = DONE;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [1:0]       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-2:0] res_q;
   logic             brw_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             borrow_q;

   logic             accept;
   logic             last_step;
   logic             fs_d;
   logic             fs_bout;
   logic [WIDTH-1:0] next_res;
   logic [WIDTH-1:0] final_res;

   assign accept    = (state_q == ST_IDLE) && bus.valid_i;
   assign last_step = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

   full_subtractor u_full_subtractor (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (brw_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   // res_q holds the WIDTH-1 bits collected so far; the final step supplies the MSB.
   assign next_res = {fs_d, res_q};

`ifdef SUB_CLAMP_EN
   assign final_res = fs_bout ? '0 : next_res;
`else
   assign final_res = next_res;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (bus.valid_i) state_q <= ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_CNT) state_q <= ST_DONE;
            ST_DONE:  if (bus.ready_i) state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         brw_q <= 1'b0;
         cnt_q <= '0;
      end else if (accept) begin
         a_q   <= bus.r1_i;
         b_q   <= bus.r2_i;
         res_q <= '0;
         brw_q <= bus.bi_i;
         cnt_q <= '0;
      end else if (state_q == ST_SHIFT) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         res_q <= next_res[WIDTH-1:1];
         brw_q <= fs_bout;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Published result only changes on the last shift, so it is held through DONE and beyond.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_q <= '0;
         borrow_q <= 1'b0;
      end else if (last_step) begin
         result_q <= final_res;
         borrow_q <= fs_bout;
      end
   end

   assign bus.ready_o  = (state_q == ST_IDLE);
   assign bus.valid_o  = (state_q == ST_DONE);
   assign bus.result_o = result_q;
   assign bus.borrow_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), honours SUB_CLAMP_EN.
module tb_serial_subtractor;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   serial_subtractor_if #(.WIDTH(4)) bus ();

   serial_subtractor #(.WIDTH(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SUB_CLAMP_EN
   localparam logic [3:0] EXP_0_MINUS_1 = 4'b0000;
   localparam logic [3:0] EXP_5_MINUS_A = 4'b0000;
`else
   localparam logic [3:0] EXP_0_MINUS_1 = 4'b1111;
   localparam logic [3:0] EXP_5_MINUS_A = 4'b1011;
`endif

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic bi);
      int         d;
      logic [3:0] r;
      logic       brw;
      d   = int'(a) - int'(b) - int'(bi);
      brw = (d < 0);
      r   = d[3:0];
`ifdef SUB_CLAMP_EN
      if (brw) r = 4'b0000;
`endif
      return {brw, r};
   endfunction

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input logic [3:0] exp_res, input logic exp_brw,
                        input int stall, input bit poke, input string tag);
      int cyc;
      check({tag, "_ready_idle"}, 32'(bus.ready_o), 32'd1);
      bus.r1_i    = a;
      bus.r2_i    = b;
      bus.bi_i    = bi;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b0;
      @(posedge clk); #1;
      bus.r1_i = ~a;
      bus.r2_i = ~b;
      bus.bi_i = ~bi;
      if (poke) begin
         check({tag, "_ready_busy"}, 32'(bus.ready_o), 32'd0);
      end else begin
         bus.valid_i = 1'b0;
      end
      cyc = 0;
      while (bus.valid_o !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (poke && bus.valid_o !== 1'b1)
            check({tag, "_ready_shift"}, 32'(bus.ready_o), 32'd0);
      end
      bus.valid_i = 1'b0;
      check({tag, "_latency"}, 32'(cyc), 32'd4);
      check({tag, "_result"}, 32'(bus.result_o), 32'(exp_res));
      check({tag, "_borrow"}, 32'(bus.borrow_o), 32'(exp_brw));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check({tag, "_stall_valid"}, 32'(bus.valid_o), 32'd1);
         check({tag, "_stall_ready"}, 32'(bus.ready_o), 32'd0);
         check({tag, "_stall_result"}, 32'(bus.result_o), 32'(exp_res));
         check({tag, "_stall_borrow"}, 32'(bus.borrow_o), 32'(exp_brw));
      end
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      check({tag, "_valid_drop"}, 32'(bus.valid_o), 32'd0);
      check({tag, "_ready_back"}, 32'(bus.ready_o), 32'd1);
      check({tag, "_result_kept"}, 32'(bus.result_o), 32'(exp_res));
   endtask

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rbi;
      logic [4:0] m;
      int         pulses;

      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      bus.valid_i  = 1'b0;
      bus.ready_i  = 1'b0;
      bus.r1_i     = '0;
      bus.r2_i     = '0;
      bus.bi_i     = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready_o), 32'd1);
      check("rst_valid", 32'(bus.valid_o), 32'd0);
      check("rst_result", 32'(bus.result_o), 32'd0);
      check("rst_borrow", 32'(bus.borrow_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(4'b1010, 4'b0010, 1'b1, 4'b0111, 1'b0, 0, 1'b0, "a_minus_2_bi");
      do_op(4'b0000, 4'b0001, 1'b0, EXP_0_MINUS_1, 1'b1, 0, 1'b0, "zero_minus_1");
      do_op(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 1'b1, "f_minus_f_poke");
      do_op(4'b0101, 4'b1010, 1'b0, EXP_5_MINUS_A, 1'b1, 5, 1'b0, "backpressure");

      // Reset two shift edges into an operation must clear outputs immediately.
      bus.r1_i    = 4'b1100;
      bus.r2_i    = 4'b0001;
      bus.bi_i    = 1'b0;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(bus.ready_o), 32'd1);
      check("midrst_valid", 32'(bus.valid_o), 32'd0);
      check("midrst_result", 32'(bus.result_o), 32'd0);
      check("midrst_borrow", 32'(bus.borrow_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.valid_o === 1'b1) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
      do_op(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, 0, 1'b0, "after_reset");

      for (int i = 0; i < 40; i++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rbi = 1'($urandom_range(0, 1));
         m   = model(ra, rb, rbi);
         do_op(ra, rb, rbi, m[3:0], m[4], int'($urandom_range(0, 3)), 1'b0, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
